// File: rtl/oam_addr_arb.sv
// oam_addr_arb: OAM address generator and single-port OAM bus arbiter.
// Ownership priority: DMA, then render, then sprite scan, then CPU.
// The owner and every OAM strobe come from registers. Each one is
// computed from the current engine state and inputs, so it shows one
// clock after it is decided.
// Build option: define OAM_ARB_DMA_EN to include the DMA engine.
// Without it, dma_busy and dma_a stay 0 and owner never reaches 3.
module oam_addr_arb #(
    parameter int N_ENTRIES   = 40,
    parameter int ENTRY_BYTES = 4,
    parameter int AW          = $clog2(N_ENTRIES * ENTRY_BYTES),
    parameter int IW          = $clog2(N_ENTRIES)
) (
    input  logic                           clk,
    input  logic                           reset_video,
    input  logic                           scan_start,
    input  logic                           render_en,
    input  logic [IW-1:0]                  render_idx,
    input  logic [$clog2(ENTRY_BYTES)-1:0] render_byte,
    input  logic                           cpu_rd,
    input  logic                           cpu_wr,
    input  logic [AW-1:0]                  cpu_a,
    input  logic [7:0]                     cpu_d,
    input  logic                           dma_start,
    input  logic [7:0]                     dma_src_hi,
    input  logic [7:0]                     md,
    output logic [15:0]                    dma_a,
    output logic                           dma_busy,
    output logic [AW-1:0]                  oam_a,
    output logic [7:0]                     oam_d,
    output logic                           oam_re,
    output logic                           oam_we,
    output logic [IW-1:0]                  scan_idx,
    output logic                           scan_busy,
    output logic                           scan_done,
    output logic                           cpu_blocked,
    output logic [1:0]                     owner
);
    localparam int              BW        = $clog2(ENTRY_BYTES);
    localparam int              TOTAL     = N_ENTRIES * ENTRY_BYTES;
    localparam logic [AW:0]     TOTAL_W   = (AW+1)'(TOTAL);
    localparam logic [AW:0]     LAST_BYTE = (AW+1)'(TOTAL - 1);
    localparam logic [IW-1:0]   LAST_IDX  = IW'(N_ENTRIES - 1);
    localparam logic [1:0]      OWN_CPU    = 2'd0;
    localparam logic [1:0]      OWN_SCAN   = 2'd1;
    localparam logic [1:0]      OWN_RENDER = 2'd2;
    localparam logic [1:0]      OWN_DMA    = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_PH0, S_PH1, S_DONE} scan_state_t;

    scan_state_t   scan_state_reg, scan_state_next;
    logic [IW-1:0] idx_reg, idx_next;
    logic          scan_active;
    logic          scan_owns;
    logic          cpu_in_range;

    logic          dma_active;
    logic          dma_fetch;
    logic          dma_write;
    logic [AW-1:0] dma_wr_addr;
    logic [15:0]   dma_fetch_addr;

    logic [15:0]   dma_a_reg, dma_a_next;
    logic          dma_busy_reg, dma_busy_next;
    logic [AW-1:0] oam_a_reg, oam_a_next;
    logic [7:0]    oam_d_reg, oam_d_next;
    logic          oam_re_reg, oam_re_next;
    logic          oam_we_reg, oam_we_next;
    logic [IW-1:0] scan_idx_reg, scan_idx_next;
    logic          scan_busy_reg, scan_busy_next;
    logic          scan_done_reg, scan_done_next;
    logic          cpu_blocked_reg, cpu_blocked_next;
    logic [1:0]    owner_reg, owner_next;

    assign scan_active  = (scan_state_reg == S_PH0) || (scan_state_reg == S_PH1);
    // The scan advances only in cycles where it actually wins the bus.
    assign scan_owns    = scan_active && !dma_active && !render_en;
    assign cpu_in_range = ({1'b0, cpu_a} < TOTAL_W);

`ifdef OAM_ARB_DMA_EN
    logic          dma_run_reg;
    logic          dma_phase_reg;   // 0 = fetch cycle, 1 = write cycle
    logic [AW:0]   dma_cnt_reg;
    logic [7:0]    dma_src_reg;

    // DMA engine: fetch/write pairs over the whole table, restarted by dma_start
    always_ff @(posedge clk) begin
        if (reset_video) begin
            dma_run_reg   <= 1'b0;
            dma_phase_reg <= 1'b0;
            dma_cnt_reg   <= '0;
            dma_src_reg   <= 8'h00;
        end else if (dma_start) begin
            dma_run_reg   <= 1'b1;
            dma_phase_reg <= 1'b0;
            dma_cnt_reg   <= '0;
            dma_src_reg   <= dma_src_hi;
        end else if (dma_run_reg) begin
            dma_phase_reg <= ~dma_phase_reg;
            if (dma_phase_reg) begin
                dma_cnt_reg <= dma_cnt_reg + (AW+1)'(1);
                if (dma_cnt_reg == LAST_BYTE) begin
                    dma_run_reg <= 1'b0;
                end
            end
        end
    end

    assign dma_active     = dma_run_reg;
    assign dma_fetch      = dma_run_reg && !dma_phase_reg;
    assign dma_write      = dma_run_reg && dma_phase_reg;
    assign dma_wr_addr    = dma_cnt_reg[AW-1:0];
    assign dma_fetch_addr = {dma_src_reg, 8'(dma_cnt_reg)};
`else
    logic unused_dma_inputs;
    assign unused_dma_inputs = ^{dma_start, dma_src_hi};
    assign dma_active     = 1'b0;
    assign dma_fetch      = 1'b0;
    assign dma_write      = 1'b0;
    assign dma_wr_addr    = '0;
    assign dma_fetch_addr = 16'h0000;
`endif

    // Scan FSM state register
    always_ff @(posedge clk) begin
        if (reset_video) begin
            scan_state_reg <= S_IDLE;
            idx_reg        <= '0;
        end else begin
            scan_state_reg <= scan_state_next;
            idx_reg        <= idx_next;
        end
    end

    // Scan FSM next state: a start always restarts; the scan holds when it loses the bus
    always_comb begin
        scan_state_next = scan_state_reg;
        idx_next        = idx_reg;
        if (scan_start) begin
            scan_state_next = S_PH0;
            idx_next        = '0;
        end else begin
            case (scan_state_reg)
                S_PH0: begin
                    if (scan_owns) begin
                        scan_state_next = S_PH1;
                    end
                end
                S_PH1: begin
                    if (scan_owns) begin
                        if (idx_reg == LAST_IDX) begin
                            scan_state_next = S_DONE;
                        end else begin
                            scan_state_next = S_PH0;
                            idx_next        = idx_reg + IW'(1);
                        end
                    end
                end
                S_DONE:  scan_state_next = S_IDLE;
                default: scan_state_next = S_IDLE;
            endcase
        end
    end

    // Output decode: choose the owner, then build that owner's strobe and address
    always_comb begin
        owner_next = OWN_CPU;
        if (dma_active) begin
            owner_next = OWN_DMA;
        end else if (render_en) begin
            owner_next = OWN_RENDER;
        end else if (scan_active) begin
            owner_next = OWN_SCAN;
        end

        oam_a_next  = '0;
        oam_d_next  = 8'h00;
        oam_re_next = 1'b0;
        oam_we_next = 1'b0;
        case (owner_next)
            OWN_DMA: begin
                if (dma_write) begin
                    oam_a_next  = dma_wr_addr;
                    oam_d_next  = md;
                    oam_we_next = 1'b1;
                end
            end
            OWN_RENDER: begin
                oam_a_next  = (AW'(render_idx) << BW) + AW'(render_byte);
                oam_re_next = 1'b1;
            end
            OWN_SCAN: begin
                oam_a_next  = (AW'(idx_reg) << BW)
                            + ((scan_state_reg == S_PH1) ? AW'(1) : AW'(0));
                oam_re_next = 1'b1;
            end
            default: begin
                // Out-of-range CPU addresses are dropped, not reported as blocked.
                if (cpu_in_range && cpu_wr) begin
                    oam_a_next  = cpu_a;
                    oam_d_next  = cpu_d;
                    oam_we_next = 1'b1;
                end else if (cpu_in_range && cpu_rd) begin
                    oam_a_next  = cpu_a;
                    oam_re_next = 1'b1;
                end
            end
        endcase

        cpu_blocked_next = (owner_next != OWN_CPU) && (cpu_rd || cpu_wr);
        dma_a_next       = dma_fetch ? dma_fetch_addr : dma_a_reg;
        dma_busy_next    = dma_active;
        scan_idx_next    = idx_reg;
        scan_busy_next   = scan_active;
        scan_done_next   = (scan_state_reg == S_DONE);
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (reset_video) begin
            dma_a_reg       <= 16'h0000;
            dma_busy_reg    <= 1'b0;
            oam_a_reg       <= '0;
            oam_d_reg       <= 8'h00;
            oam_re_reg      <= 1'b0;
            oam_we_reg      <= 1'b0;
            scan_idx_reg    <= '0;
            scan_busy_reg   <= 1'b0;
            scan_done_reg   <= 1'b0;
            cpu_blocked_reg <= 1'b0;
            owner_reg       <= OWN_CPU;
        end else begin
            dma_a_reg       <= dma_a_next;
            dma_busy_reg    <= dma_busy_next;
            oam_a_reg       <= oam_a_next;
            oam_d_reg       <= oam_d_next;
            oam_re_reg      <= oam_re_next;
            oam_we_reg      <= oam_we_next;
            scan_idx_reg    <= scan_idx_next;
            scan_busy_reg   <= scan_busy_next;
            scan_done_reg   <= scan_done_next;
            cpu_blocked_reg <= cpu_blocked_next;
            owner_reg       <= owner_next;
        end
    end

    assign dma_a       = dma_a_reg;
    assign dma_busy    = dma_busy_reg;
    assign oam_a       = oam_a_reg;
    assign oam_d       = oam_d_reg;
    assign oam_re      = oam_re_reg;
    assign oam_we      = oam_we_reg;
    assign scan_idx    = scan_idx_reg;
    assign scan_busy   = scan_busy_reg;
    assign scan_done   = scan_done_reg;
    assign cpu_blocked = cpu_blocked_reg;
    assign owner       = owner_reg;

endmodule

// File: tb/tb_oam_addr_arb.sv
// tb_oam_addr_arb: scoreboard bench for oam_addr_arb (N_ENTRIES=40, ENTRY_BYTES=4).
// The stimulus process runs a behavioural model once per cycle and queues the
// expected registered outputs. A monitor pops and compares them after each edge.
module tb_oam_addr_arb;
    localparam int N     = 40;
    localparam int EB    = 4;
    localparam int TOTAL = N * EB;
    localparam int AW    = 8;
    localparam int IW    = 6;
    localparam int BW    = 2;

    logic          clk = 1'b0;
    logic          reset_video, scan_start, render_en;
    logic [IW-1:0] render_idx;
    logic [BW-1:0] render_byte;
    logic          cpu_rd, cpu_wr;
    logic [AW-1:0] cpu_a;
    logic [7:0]    cpu_d;
    logic          dma_start;
    logic [7:0]    dma_src_hi;
    logic [7:0]    md;
    logic [15:0]   dma_a;
    logic          dma_busy;
    logic [AW-1:0] oam_a;
    logic [7:0]    oam_d;
    logic          oam_re, oam_we;
    logic [IW-1:0] scan_idx;
    logic          scan_busy, scan_done, cpu_blocked;
    logic [1:0]    owner;

    always #5 clk = ~clk;

    // Source memory returns the low byte of the address presented.
    assign md = dma_a[7:0];

    oam_addr_arb #(.N_ENTRIES(N), .ENTRY_BYTES(EB)) dut (
        .clk(clk), .reset_video(reset_video), .scan_start(scan_start),
        .render_en(render_en), .render_idx(render_idx), .render_byte(render_byte),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_a(cpu_a), .cpu_d(cpu_d),
        .dma_start(dma_start), .dma_src_hi(dma_src_hi), .md(md),
        .dma_a(dma_a), .dma_busy(dma_busy), .oam_a(oam_a), .oam_d(oam_d),
        .oam_re(oam_re), .oam_we(oam_we), .scan_idx(scan_idx),
        .scan_busy(scan_busy), .scan_done(scan_done),
        .cpu_blocked(cpu_blocked), .owner(owner)
    );

    typedef struct packed {
        logic [15:0]   dma_a;
        logic          dma_busy;
        logic [AW-1:0] oam_a;
        logic [7:0]    oam_d;
        logic          oam_re;
        logic          oam_we;
        logic [IW-1:0] scan_idx;
        logic          scan_busy;
        logic          scan_done;
        logic          cpu_blocked;
        logic [1:0]    owner;
    } out_t;

    typedef struct packed {
        out_t v;
        logic care_a;
        logic care_d;
        logic care_dma;
        logic care_idx;
    } exp_t;

    exp_t    exp_q[$];
    int      scan_addrs[$];
    int      checks = 0;
    int      errors = 0;
    int      cyc = 0;

    // Model state: scan position counts read slots 0..2N-1, DMA position counts cycles 0..2*TOTAL-1.
    bit          sc_act = 0;
    bit          sc_done_pend = 0;
    int          sc_pos = 0;
    int          sc_entry = 0;
    bit          dm_act = 0;
    int          dm_pos = 0;
    logic [7:0]  dm_src = 8'h00;

    task automatic check(string name, int got, int req);
        checks++;
        if (got != req) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", name, got, got, req, req);
        end
    endtask

    task automatic model_cycle(output exp_t e);
        int own;
        e = '0;
        if (reset_video) begin
            e.care_a = 1; e.care_d = 1; e.care_dma = 1; e.care_idx = 1;
            sc_act = 0; sc_done_pend = 0; sc_pos = 0; sc_entry = 0;
            dm_act = 0; dm_pos = 0;
            return;
        end
        own = dm_act ? 3 : (render_en ? 2 : (sc_act ? 1 : 0));
        e.v.owner     = 2'(own);
        e.v.dma_busy  = dm_act;
        e.v.scan_busy = sc_act;
        e.v.scan_done = sc_done_pend;
        e.v.scan_idx  = IW'(sc_entry);
        e.care_idx    = sc_act;
`ifndef OAM_ARB_DMA_EN
        e.care_dma    = 1;
`endif
        if (own == 3) begin
            if (dm_pos % 2 == 0) begin
                e.v.dma_a = {dm_src, 8'(dm_pos / 2)};
                e.care_dma = 1;
            end else begin
                e.v.oam_we = 1; e.v.oam_a = AW'(dm_pos / 2); e.v.oam_d = 8'(dm_pos / 2);
                e.care_a = 1; e.care_d = 1;
            end
        end else if (own == 2) begin
            e.v.oam_re = 1; e.v.oam_a = AW'(int'(render_idx) * EB + int'(render_byte));
            e.care_a = 1;
        end else if (own == 1) begin
            e.v.oam_re = 1; e.v.oam_a = AW'((sc_pos / 2) * EB + (sc_pos % 2));
            e.care_a = 1;
        end else if ((cpu_rd || cpu_wr) && int'(cpu_a) < TOTAL) begin
            e.care_a = 1; e.v.oam_a = cpu_a;
            if (cpu_wr) begin
                e.v.oam_we = 1; e.v.oam_d = cpu_d; e.care_d = 1;
            end else begin
                e.v.oam_re = 1;
            end
        end
        e.v.cpu_blocked = (own != 0) && (cpu_rd || cpu_wr);

        if (scan_start) begin
            sc_act = 1; sc_pos = 0; sc_entry = 0; sc_done_pend = 0;
        end else if (sc_done_pend) begin
            sc_done_pend = 0;
        end else if (own == 1) begin
            if (sc_pos == 2 * N - 1) begin
                sc_act = 0; sc_done_pend = 1;
            end else begin
                sc_pos++; sc_entry = sc_pos / 2;
            end
        end
`ifdef OAM_ARB_DMA_EN
        if (dma_start) begin
            dm_act = 1; dm_pos = 0; dm_src = dma_src_hi;
        end else if (dm_act) begin
            if (dm_pos == 2 * TOTAL - 1) dm_act = 0;
            else dm_pos++;
        end
`endif
    endtask

    task automatic step();
        exp_t e;
        model_cycle(e);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle_inputs();
        reset_video = 0; scan_start = 0; render_en = 0; render_idx = '0; render_byte = '0;
        cpu_rd = 0; cpu_wr = 0; cpu_a = '0; cpu_d = 8'h00; dma_start = 0; dma_src_hi = 8'h00;
    endtask

    task automatic check_scan_seq(string name);
        int bad;
        bad = -1;
        for (int i = 0; i < scan_addrs.size(); i++) begin
            if (bad < 0 && scan_addrs[i] != (i / 2) * EB + (i % 2)) bad = i;
        end
        check({name, "_len"}, scan_addrs.size(), 2 * N);
        check({name, "_first_bad_index"}, bad, -1);
    endtask

    task automatic wait_scan_done(string name, int start, int req_latency);
        int cnt, at;
        cnt = 0; at = -1;
        for (int i = 0; i < 150; i++) begin
            step();
            if (scan_done) begin
                cnt++;
                if (at < 0) at = cyc - start;
            end
        end
        check({name, "_done_count"}, cnt, 1);
        if (req_latency > 0) check({name, "_done_latency"}, at, req_latency);
    endtask

    // Monitor: compare each registered output vector against the queued expectation
    always @(posedge clk) begin
        exp_t e;
        bit   ok;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            ok = (owner == e.v.owner) && (oam_re == e.v.oam_re) && (oam_we == e.v.oam_we)
              && (cpu_blocked == e.v.cpu_blocked) && (scan_busy == e.v.scan_busy)
              && (scan_done == e.v.scan_done) && (dma_busy == e.v.dma_busy)
              && (!e.care_a || oam_a == e.v.oam_a) && (!e.care_d || oam_d == e.v.oam_d)
              && (!e.care_dma || dma_a == e.v.dma_a) && (!e.care_idx || scan_idx == e.v.scan_idx);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL out_vector t=%0t: got owner=%0d re=%0d we=%0d a=%02h d=%02h blk=%0d sbusy=%0d sdone=%0d sidx=%0d dbusy=%0d dma_a=%04h required owner=%0d re=%0d we=%0d a=%02h d=%02h blk=%0d sbusy=%0d sdone=%0d sidx=%0d dbusy=%0d dma_a=%04h",
                    $time, owner, oam_re, oam_we, oam_a, oam_d, cpu_blocked, scan_busy, scan_done, scan_idx, dma_busy, dma_a,
                    e.v.owner, e.v.oam_re, e.v.oam_we, e.v.oam_a, e.v.oam_d, e.v.cpu_blocked, e.v.scan_busy, e.v.scan_done,
                    e.v.scan_idx, e.v.dma_busy, e.v.dma_a);
            end
            if (owner == 2'd1 && oam_re) scan_addrs.push_back(int'(oam_a));
            if (oam_re || oam_we)
                $display("txn t=%0t owner=%0d re=%0d we=%0d a=%02h d=%02h", $time, owner, oam_re, oam_we, oam_a, oam_d);
        end
    end

    initial begin
        int start, guard;
        idle_inputs();
        reset_video = 1;
        repeat (3) step();
        check("reset_owner", owner, 0);
        check("reset_dma_a", dma_a, 0);
        check("reset_strobes", {oam_re, oam_we, cpu_blocked, dma_busy}, 0);
        check("reset_scan", {scan_busy, scan_done}, 0);
        check("reset_oam_a", oam_a, 0);
        reset_video = 0;
        step();

        // Uncontested scan
        scan_addrs.delete();
        scan_start = 1; step(); scan_start = 0; start = cyc;
        wait_scan_done("scan_plain", start, 2 * N + 1);
        check_scan_seq("scan_plain_seq");

        // CPU while idle: write, out-of-range read, read+write together
        cpu_wr = 1; cpu_a = 8'h20; cpu_d = 8'h5A; step(); cpu_wr = 0;
        check("cpu_wr_idle_we", oam_we, 1);
        check("cpu_wr_idle_a", oam_a, 8'h20);
        check("cpu_wr_idle_d", oam_d, 8'h5A);
        check("cpu_wr_idle_blocked", cpu_blocked, 0);
        cpu_rd = 1; cpu_a = 8'hA0; step(); cpu_rd = 0;
        check("cpu_rd_oor_strobes", {oam_re, oam_we, cpu_blocked}, 0);
        cpu_rd = 1; cpu_wr = 1; cpu_a = 8'h9F; cpu_d = 8'h33; step(); cpu_rd = 0; cpu_wr = 0;
        check("cpu_rdwr_write_wins", {oam_re, oam_we}, 1);

        // Scan with render stealing the bus at entry 10, PH1
        scan_addrs.delete();
        scan_start = 1; step(); scan_start = 0; start = cyc;
        guard = 0;
        while (!(sc_act && sc_pos == 21) && guard < 100) begin step(); guard++; end
        check("render_reach_entry10", guard < 100, 1);
        render_en = 1; render_idx = 6'd33; render_byte = 2'd2;
        for (int i = 0; i < 6; i++) begin
            step();
            check("render_owner", owner, 2);
            check("render_scan_idx_frozen", scan_idx, 10);
        end
        render_en = 0;
        repeat (3) step();
        cpu_wr = 1; cpu_a = 8'h20; cpu_d = 8'h5A; step(); cpu_wr = 0;
        check("cpu_wr_scanning_blocked", cpu_blocked, 1);
        check("cpu_wr_scanning_we", oam_we, 0);
        wait_scan_done("scan_render", start, 0);
        check_scan_seq("scan_render_seq");

        // Randomised traffic
        for (int i = 0; i < 700; i++) begin
            reset_video = ($urandom_range(0, 199) == 0);
            scan_start  = ($urandom_range(0, 69) == 0);
            render_en   = ($urandom_range(0, 3) == 0);
            render_idx  = IW'($urandom_range(0, N - 1));
            render_byte = BW'($urandom);
            cpu_rd      = ($urandom_range(0, 2) == 0);
            cpu_wr      = ($urandom_range(0, 2) == 0);
            cpu_a       = AW'($urandom);
            cpu_d       = 8'($urandom);
            dma_start   = ($urandom_range(0, 249) == 0);
            dma_src_hi  = 8'($urandom);
            step();
        end
        idle_inputs();
        reset_video = 1; step(); reset_video = 0; step();

`ifdef OAM_ARB_DMA_EN
        begin
            int wr, low_at;
            logic [15:0] first_a, last_a;
            dma_src_hi = 8'hC1; dma_start = 1; step(); dma_start = 0; start = cyc;
            wr = 0; low_at = -1; first_a = 16'h0; last_a = 16'h0;
            for (int i = 0; i < 400 && low_at < 0; i++) begin
                step();
                if (oam_we) wr++;
                if (dma_busy && i == 0) first_a = dma_a;
                if (dma_busy) last_a = dma_a;
                if (!dma_busy) low_at = cyc - start;
            end
            check("dma_write_count", wr, TOTAL);
            check("dma_first_addr", first_a, 16'hC100);
            check("dma_last_addr", last_a, 16'hC19F);
            check("dma_busy_low_latency", low_at, 2 * TOTAL + 1);
        end
        // Restart at byte 50, then reset mid-transfer
        dma_src_hi = 8'hC1; dma_start = 1; step(); dma_start = 0;
        guard = 0;
        while (dm_pos != 100 && guard < 200) begin step(); guard++; end
        dma_start = 1; step(); dma_start = 0;
        step();
        check("dma_restart_fetch_lo", dma_a[7:0], 0);
        step();
        check("dma_restart_write_a", {oam_we, oam_a}, {1'b1, 8'h00});
        repeat (7) step();
        reset_video = 1; step(); reset_video = 0;
        check("dma_reset_busy", dma_busy, 0);
        check("dma_reset_dma_a", dma_a, 0);
        check("dma_reset_owner_we", {owner, oam_we}, 0);
        // Simultaneous scan_start and dma_start
        scan_start = 1; dma_start = 1; dma_src_hi = 8'h44; step(); scan_start = 0; dma_start = 0;
        repeat (4) step();
        check("both_owner_dma", owner, 3);
        check("both_scan_hold", {scan_busy, scan_idx}, {1'b1, 6'd0});
        repeat (2 * TOTAL + 2 * N + 10) step();
`else
        dma_start = 1; dma_src_hi = 8'hC1; cpu_wr = 1; cpu_a = 8'h33; cpu_d = 8'hA5; step();
        dma_start = 0; cpu_wr = 0;
        check("nodma_busy", dma_busy, 0);
        check("nodma_cpu_we", {owner, oam_we, oam_a, oam_d}, {2'd0, 1'b1, 8'h33, 8'hA5});
        repeat (4) step();
        check("nodma_busy_later", {dma_busy, dma_a}, 0);
`endif

        idle_inputs();
        step(); step();
        @(posedge clk); #2;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/oam_addr_arb.md
# oam_addr_arb

Parametrised OAM address generator and bus arbiter for the video block, in the same position as the existing OAM address/control logic. Generalises that logic in three ways: configurable sprite count and entry size, an internal DMA engine with its own byte counter, and explicit CPU-blocked reporting. It sequences the sprite-scan counter and arbitrates one OAM port between DMA, render, scan and CPU. The owner and all OAM strobes are registered.

## Interface
Parameters:
- `N_ENTRIES`, 40: number of sprite entries.
- `ENTRY_BYTES`, 4: bytes per entry. Must be a power of two. `N_ENTRIES*ENTRY_BYTES` must be 256 or less.
- `AW`, `$clog2(N_ENTRIES*ENTRY_BYTES)`: OAM byte address width. Derived; do not override.
- `IW`, `$clog2(N_ENTRIES)`: entry index width. Derived.

Ports:
- `clk` in 1: video clock. All state changes on the rising edge.
- `reset_video` in 1: synchronous, active-high reset.
- `scan_start` in 1: one-cycle pulse that starts a sprite scan.
- `render_en` in 1: renderer requests the bus.
- `render_idx` in IW: entry index for render.
- `render_byte` in `$clog2(ENTRY_BYTES)`: byte within the entry for render.
- `cpu_rd` in 1: CPU read strobe.
- `cpu_wr` in 1: CPU write strobe.
- `cpu_a` in AW: CPU OAM byte address.
- `cpu_d` in 8: CPU write data.
- `dma_start` in 1: pulse that starts a DMA transfer.
- `dma_src_hi` in 8: DMA source page.
- `md` in 8: source data returned for `dma_a`.
- `dma_a` out 16: DMA source address.
- `dma_busy` out 1: DMA in progress.
- `oam_a` out AW: OAM byte address.
- `oam_d` out 8: OAM write data.
- `oam_re` out 1: OAM read strobe.
- `oam_we` out 1: OAM write strobe.
- `scan_idx` out IW: current scan entry.
- `scan_busy` out 1: scan in progress.
- `scan_done` out 1: one-cycle pulse at scan end.
- `cpu_blocked` out 1: CPU access this cycle was refused.
- `owner` out 2: current bus owner. 0 = CPU/idle, 1 = scan, 2 = render, 3 = DMA.

## Operation
Ownership priority: DMA (`dma_busy`), then render (`render_en`), then scan (`scan_busy`), then CPU.

Scan:
- FSM states: IDLE, PH0, PH1, DONE.
- `scan_start` loads `scan_idx`=0 and enters PH0. This applies from any state, including a restart mid-scan.
- PH0 drives `oam_a` = idx*ENTRY_BYTES + 0 (Y byte) with `oam_re`. PH1 drives offset 1 (X byte) with `oam_re`.
- PH1 advances to PH0 with idx+1. If idx = N_ENTRIES-1, PH1 goes to DONE instead.
- DONE asserts `scan_done` for one cycle and returns to IDLE.
- While scan does not own the bus (DMA or render active), phase and idx hold.

Render: `oam_a` = render_idx*ENTRY_BYTES + render_byte, with `oam_re`=1.

DMA:
- `dma_start` clears the byte counter `cnt` (AW+1 bits) and sets `dma_busy`. This applies even while a transfer is in progress, which restarts it.
- Each byte takes two cycles.
- Fetch cycle: `dma_a` = {dma_src_hi latched at start, cnt zero-extended to 8}.
- Write cycle: `oam_a`=cnt, `oam_d`=md, `oam_we`=1, then cnt increments.
- After byte N_ENTRIES*ENTRY_BYTES-1 is written, `dma_busy` clears.

CPU:
- Applies only when `owner` would be 0.
- `cpu_wr` gives `oam_we`=1, `oam_a`=cpu_a, `oam_d`=cpu_d.
- `cpu_rd` gives `oam_re`=1.
- If both are high, write wins.
- `cpu_a` at or above N_ENTRIES*ENTRY_BYTES: no strobe, `cpu_blocked`=0.
- Any `cpu_rd`/`cpu_wr` while `owner` is not 0: no strobe, `cpu_blocked`=1.

## Timing
- Reset values: all outputs 0. `dma_a`=0x0000, `owner`=0. Scan FSM in IDLE, DMA idle.
- All outputs are registered. A request sampled at edge n appears after edge n+1 (one-cycle latency).
- `scan_start` at edge n: PH0 for entry 0 is visible after edge n+1.
- Scan length uncontested: `scan_done` comes 2*N_ENTRIES+1 cycles after `scan_start`.
- DMA length: 2*N_ENTRIES*ENTRY_BYTES cycles plus one cycle of start latency.
- Simultaneous `scan_start` and `dma_start`: both are accepted. DMA owns the bus and scan holds at PH0, idx 0.
- `reset_video` mid-operation aborts scan and DMA next edge. No `scan_done` is emitted.
- `md` is sampled on the edge that ends the fetch cycle.

## Configuration
- `OAM_ARB_DMA_EN` defined: DMA engine present as described.
- Not defined: DMA logic is removed. `dma_start` and `md` are ignored, `dma_busy`=0, `dma_a`=0, and `owner` is never 3.

## Test plan
- Reset, then `scan_start` with N_ENTRIES=40, ENTRY_BYTES=4. Expect `oam_a` sequence 0,1,4,5,…,156,157. `scan_done` pulses exactly once, 81 cycles after start.
- `dma_start` with `dma_src_hi`=0xC1 and `md` = low byte of `dma_a`. Expect 160 writes, `oam_a`=k with `oam_d`=k. `dma_a` runs 0xC100–0xC19F. `dma_busy` is low after 321 cycles.
- `render_en` asserted for 6 cycles at scan entry 10, PH1. Expect `owner`=2 and idx/phase frozen at 10/PH1. The scan resumes at offset 41 with no skipped entry.
- `cpu_wr` to 0x20 with data 0x5A while scanning: expect `cpu_blocked`=1 and no `oam_we`. The same write when idle: `oam_we`=1, `oam_a`=0x20, `oam_d`=0x5A.
- `dma_start` again at byte 50: expect the counter to restart at 0 and `dma_a` low byte 0x00. `reset_video` asserted mid-DMA: all outputs 0 the next cycle.
- Build without `OAM_ARB_DMA_EN` and pulse `dma_start`: `dma_busy` stays 0 and CPU access is unaffected.
